// File: rtl/im_server.sv
// im_server: multi-cycle instruction store answering one word-aligned fetch at a time
// after a fixed latency, with a run-time program-load write port.
module im_server #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [31:0]           rsp_addr,
    output logic                  rsp_fault,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic                  fault_q, fault_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           raddr_q, raddr_d;
    logic                  rfault_q, rfault_d;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [31:0]           off;

    assign off       = req_addr - BASE_ADDR;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_instr = instr_q;
    assign rsp_addr  = raddr_q;
    assign rsp_fault = rfault_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        fault_d  = fault_q;
        idx_d    = idx_q;
        instr_d  = instr_q;
        raddr_d  = raddr_q;
        rfault_d = rfault_q;
        if (state_q == IDLE && req_valid) begin
            state_d = WAIT;
            cnt_d   = 2'(LATENCY - 1);
            addr_d  = req_addr;
            idx_d   = off[DEPTH_LOG2+1:2];
            fault_d = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR)
                      || ({1'b0, off} >= (33'd1 << (DEPTH_LOG2 + 2)));
        end else if (state_q == WAIT) begin
            if (cnt_q == 2'd0) begin
                // mem still holds the pre-edge value here, giving read-before-write on a same-edge load
                state_d  = RESP;
                instr_d  = fault_q ? 32'h0 : mem[idx_q];
                raddr_d  = addr_q;
                rfault_d = fault_q;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            fault_q  <= 1'b0;
            idx_q    <= '0;
            instr_q  <= '0;
            raddr_q  <= '0;
            rfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            fault_q  <= fault_d;
            idx_q    <= idx_d;
            instr_q  <= instr_d;
            raddr_q  <= raddr_d;
            rfault_q <= rfault_d;
        end
    end

    // Memory is deliberately outside reset; only the load port changes it.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end
endmodule

// File: tb/tb_im_server.sv
// tb_im_server: three im_server instances (LATENCY 2, 1, 4) sharing one load port,
// checked against a word-array model of memory and the fetch rules.
module tb_im_server;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_instr [3];
    logic [31:0] rsp_addr  [3];
    logic        rsp_fault [3];
    logic        busy      [3];
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem_m [4096];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        im_server #(
            .DEPTH_LOG2(12),
            .BASE_ADDR (32'h0000_3000),
            .LATENCY   (g == 0 ? 2 : g == 1 ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_instr(rsp_instr[g]),
            .rsp_addr (rsp_addr[g]),
            .rsp_fault(rsp_fault[g]),
            .ld_en    (ld_en),
            .ld_addr  (ld_addr),
            .ld_data  (ld_data),
            .busy     (busy[g])
        );
    end

    function automatic int lat(input int k);
        return k == 0 ? 2 : k == 1 ? 1 : 4;
    endfunction

    function automatic logic m_fault(input logic [31:0] a);
        longint o;
        o = longint'(a) - longint'(32'h3000);
        return (a % 4 != 0) || (o < 0) || (o >= 4 * 4096);
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        if (m_fault(a)) return 32'h0;
        return mem_m[(a - 32'h3000) / 4];
    endfunction

    task automatic load(input int i, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = 12'(i);
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        mem_m[i] = d;
    endtask

    task automatic fetch(input int k, input logic [31:0] a, input int hold, input logic noise);
        logic [31:0] ei;
        logic        ef;
        int          n;
        ef = m_fault(a);
        ei = m_instr(a);
        checks++;
        if (req_ready[k] !== 1'b1) $display("FAIL idle_ready k=%0d got %b want 1", k, req_ready[k]);
        else passed++;
        req_valid[k] = 1'b1;
        req_addr[k] = a;
        @(posedge clk); #1;
        req_valid[k] = noise;
        req_addr[k] = $urandom;
        n = 0;
        while (rsp_valid[k] !== 1'b1 && n < 8) begin
            checks++;
            if (req_ready[k] !== 1'b0 || busy[k] !== 1'b1)
                $display("FAIL wait_flags k=%0d got ready=%b busy=%b want 0/1", k, req_ready[k], busy[k]);
            else passed++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== lat(k)) $display("FAIL latency k=%0d a=%h got %0d want %0d", k, a, n, lat(k));
        else passed++;
        checks++;
        if (rsp_instr[k] !== ei || rsp_fault[k] !== ef)
            $display("FAIL rsp_data k=%0d a=%h got %h/%b want %h/%b", k, a, rsp_instr[k], rsp_fault[k], ei, ef);
        else passed++;
        checks++;
        if (rsp_addr[k] !== a || req_ready[k] !== 1'b0 || busy[k] !== 1'b1)
            $display("FAIL rsp_addr k=%0d got %h ready=%b busy=%b want %h 0 1", k, rsp_addr[k], req_ready[k], busy[k], a);
        else passed++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[k] !== 1'b1 || rsp_instr[k] !== ei || req_ready[k] !== 1'b0)
                $display("FAIL hold k=%0d got v=%b %h r=%b want 1 %h 0", k, rsp_valid[k], rsp_instr[k], req_ready[k], ei);
            else passed++;
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || busy[k] !== 1'b0)
            $display("FAIL release k=%0d got v=%b r=%b b=%b want 0 1 0", k, rsp_valid[k], req_ready[k], busy[k]);
        else passed++;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_instr[k] !== 32'h0 || rsp_addr[k] !== 32'h0
                || rsp_fault[k] !== 1'b0 || busy[k] !== 1'b0 || req_ready[k] !== 1'b1)
                $display("FAIL reset_state k=%0d got v=%b i=%h a=%h f=%b b=%b r=%b", k, rsp_valid[k],
                         rsp_instr[k], rsp_addr[k], rsp_fault[k], busy[k], req_ready[k]);
            else passed++;
        end
    endtask

    task automatic test_basic;
        fetch(0, 32'h3000, 0, 1'b0);
        fetch(0, 32'h3004, 5, 1'b1);
        fetch(0, 32'h6FFC, 1, 1'b0);
    endtask

    task automatic test_back_to_back(input int k);
        int acc[$];
        req_valid[k] = 1'b1;
        rsp_ready[k] = 1'b1;
        req_addr[k] = 32'h3000;
        for (int c = 0; c < 3 * (lat(k) + 2); c++) begin
            if (req_ready[k] === 1'b1) acc.push_back(c);
            @(posedge clk); #1;
            checks++;
            if (req_ready[k] === 1'b1 && rsp_valid[k] === 1'b1)
                $display("FAIL ready_and_valid k=%0d got both high want exclusive", k);
            else passed++;
        end
        req_valid[k] = 1'b0;
        for (int i = 0; i < 10 && req_ready[k] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        rsp_ready[k] = 1'b0;
        checks++;
        if (acc.size() != 3 || acc[1] - acc[0] != lat(k) + 2 || acc[2] - acc[1] != lat(k) + 2)
            $display("FAIL period k=%0d got %0d accepts first gap %0d want 3 accepts gap %0d", k,
                     acc.size(), acc.size() > 1 ? acc[1] - acc[0] : -1, lat(k) + 2);
        else passed++;
    endtask

    task automatic test_fault;
        fetch(0, 32'h3002, 0, 1'b0);
        fetch(0, 32'h2FFC, 0, 1'b0);
        fetch(0, 32'h7000, 0, 1'b0);
        fetch(0, 32'hFFFF_FFFC, 0, 1'b0);
    endtask

    task automatic test_load;
        load(5, 32'hDEAD_BEEF);
        fetch(0, 32'h3014, 0, 1'b0);
        req_valid[0] = 1'b1;
        req_addr[0] = 32'h3014;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        ld_en = 1'b1;
        ld_addr = 12'd5;
        ld_data = 32'h1234_5678;
        @(posedge clk); #1;
        ld_en = 1'b0;
        mem_m[5] = 32'h1234_5678;
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_instr[0] !== 32'hDEAD_BEEF)
            $display("FAIL rbw got v=%b %h want 1 deadbeef", rsp_valid[0], rsp_instr[0]);
        else passed++;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        fetch(0, 32'h3014, 0, 1'b0);
    endtask

    task automatic test_async_reset;
        fetch(2, 32'h3014, 0, 1'b0);
        req_valid[2] = 1'b1;
        req_addr[2] = 32'h3008;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0
            || rsp_instr[2] !== 32'h0 || rsp_addr[2] !== 32'h0 || rsp_fault[2] !== 1'b0)
            $display("FAIL async_clear got b=%b r=%b v=%b i=%h a=%h want 0 1 0 0 0", busy[2],
                     req_ready[2], rsp_valid[2], rsp_instr[2], rsp_addr[2]);
        else passed++;
        @(posedge clk); #2;
        checks++;
        if (req_ready[2] !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready[2]);
        else passed++;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[2] !== 1'b0) $display("FAIL dropped_req got rsp_valid=%b want 0", rsp_valid[2]);
            else passed++;
        end
    endtask

    task automatic test_latency_sweep;
        fetch(1, 32'h3000 + 4 * $urandom_range(0, 4095), 1, 1'b1);
        fetch(2, 32'h3000 + 4 * $urandom_range(0, 4095), 2, 1'b1);
        fetch(1, 32'h3001, 0, 1'b1);
        fetch(2, 32'h7000, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int          k;
            int          r;
            logic [31:0] a;
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            a = r < 6 ? 32'h3000 + 4 * $urandom_range(0, 4095)
              : r == 6 ? 32'h3000 + $urandom_range(0, 16383) | 32'h1
              : r == 7 ? $urandom_range(0, 32'h2FFF)
              : r == 8 ? 32'h7000 + $urandom_range(0, 32'h0FFF_0000)
              : $urandom;
            if ($urandom_range(0, 2) == 0) load(m_fault(a) ? $urandom_range(0, 4095) : (a - 32'h3000) / 4, $urandom);
            fetch(k, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k] = '0;
            rsp_ready[k] = 1'b0;
        end
        #2;
        test_reset;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4096; i++) load(i, $urandom);
        test_basic;
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        test_fault;
        test_load;
        test_async_reset;
        test_latency_sweep;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
